// File: rtl/add_sub_serial.sv
// Digit-serial add/subtract unit with ARM-style NZCV flags.
// Operands are resolved to (x, y, k) at accept time. The sum is then built
// CHUNK bits per clock, least-significant chunk first. The finished result and
// flags are published together when the block enters DONE.
module add_sub_serial #(
    parameter int WIDTH = 32,   // operand width, at least 2
    parameter int CHUNK = 8     // bits per cycle, must divide WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic             carry_r;
    logic             zacc_r;
    logic [WIDTH-1:0] res_r;

    logic [WIDTH-1:0] s_r;
    logic             n_r;
    logic             z_r;
    logic             c_r;
    logic             v_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [WIDTH-1:0] x_s;
    logic [WIDTH-1:0] y_s;
    logic             k_s;
    logic [CHUNK:0]   chunk_sum_s;
    logic [WIDTH-1:0] res_next_s;
    logic             accept_s;
    logic             step_s;
    logic             last_s;
    logic             deliver_s;

    // Map the opcode onto effective operands and initial carry.
    // Reserved codes fall back to plain ADD.
    always_comb begin
        x_s = a;
        y_s = b;
        k_s = 1'b0;
        case (op)
            3'b000: begin x_s = a; y_s = b;  k_s = 1'b0; end  // ADD
            3'b001: begin x_s = a; y_s = b;  k_s = c_in; end  // ADC
            3'b010: begin x_s = a; y_s = ~b; k_s = 1'b1; end  // SUB
            3'b011: begin x_s = a; y_s = ~b; k_s = c_in; end  // SBC
            3'b100: begin x_s = b; y_s = ~a; k_s = 1'b1; end  // RSB
            3'b101: begin x_s = b; y_s = ~a; k_s = c_in; end  // RSC
            default: begin x_s = a; y_s = b; k_s = 1'b0; end  // reserved -> ADD
        endcase
    end

    // One chunk of the ripple: the low CHUNK bits of the shifting operands plus the carry.
    // The result chunk enters the working register from the top, so after N steps
    // chunk 0 has reached the bottom.
    always_comb begin
        chunk_sum_s = {1'b0, x_r[CHUNK-1:0]} + {1'b0, y_r[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, carry_r};
        res_next_s  = (res_r >> CHUNK)
                    | (WIDTH'(chunk_sum_s[CHUNK-1:0]) << (WIDTH - CHUNK));
        last_s      = (cnt_r == LAST);
    end

    // Next-state logic and handshake qualifiers.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        step_s    = 1'b0;
        deliver_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    deliver_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s   = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latching and per-chunk datapath.
    // The operands shift right so chunk[cnt] is always in the low bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r     <= {WIDTH{1'b0}};
            y_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            zacc_r  <= 1'b0;
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else if (accept_s) begin
            x_r     <= x_s;
            y_r     <= y_s;
            carry_r <= k_s;
            zacc_r  <= 1'b0;
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else if (step_s) begin
            x_r     <= x_r >> CHUNK;
            y_r     <= y_r >> CHUNK;
            carry_r <= chunk_sum_s[CHUNK];
            zacc_r  <= zacc_r | (|chunk_sum_s[CHUNK-1:0]);
            res_r   <= res_next_s;
            cnt_r   <= cnt_r + CW'(1);
        end
    end

    // Publish the result and flags on the last RUN step only, so they stay frozen otherwise.
    // On the last step the low bits of x_r/y_r hold the operand MSB chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r <= {WIDTH{1'b0}};
            n_r <= 1'b0;
            z_r <= 1'b0;
            c_r <= 1'b0;
            v_r <= 1'b0;
        end else if (step_s && last_s) begin
            s_r <= res_next_s;
            n_r <= chunk_sum_s[CHUNK-1];
            z_r <= ~(zacc_r | (|chunk_sum_s[CHUNK-1:0]));
            c_r <= chunk_sum_s[CHUNK];
            v_r <= (x_r[CHUNK-1] == y_r[CHUNK-1]) &&
                   (chunk_sum_s[CHUNK-1] != x_r[CHUNK-1]);
        end
    end

    // Registered handshake outputs. Accept and deliver never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                in_ready_r <= 1'b0;
            end else if (deliver_s) begin
                in_ready_r <= 1'b1;
            end
            if (step_s && last_s) begin
                out_valid_r <= 1'b1;
            end else if (deliver_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign s         = s_r;
    assign n         = n_r;
    assign z         = z_r;
    assign c         = c_r;
    assign v         = v_r;

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: three configurations (32/8, 32/32, 64/16) share one input bus.
// sel chooses which instance sees in_valid and whose outputs are observed.
module tb_add_sub_serial;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  sel;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] a_bus;
    logic [63:0] b_bus;
    logic        c_in;
    logic [2:0]  op;

    logic [2:0]  in_ready_v, out_valid_v, n_v, z_v, c_v, v_v;
    logic [31:0] s0, s1;
    logic [63:0] s2;

    add_sub_serial #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2'd0)), .in_ready(in_ready_v[0]),
        .a(a_bus[31:0]), .b(b_bus[31:0]), .c_in(c_in), .op(op),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .s(s0),
        .n(n_v[0]), .z(z_v[0]), .c(c_v[0]), .v(v_v[0]));

    add_sub_serial #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2'd1)), .in_ready(in_ready_v[1]),
        .a(a_bus[31:0]), .b(b_bus[31:0]), .c_in(c_in), .op(op),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .s(s1),
        .n(n_v[1]), .z(z_v[1]), .c(c_v[1]), .v(v_v[1]));

    add_sub_serial #(.WIDTH(64), .CHUNK(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2'd2)), .in_ready(in_ready_v[2]),
        .a(a_bus), .b(b_bus), .c_in(c_in), .op(op),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .s(s2),
        .n(n_v[2]), .z(z_v[2]), .c(c_v[2]), .v(v_v[2]));

    logic [63:0] s_cur;
    logic [3:0]  f_cur;
    logic        rdy_cur, vld_cur;

    // View of the currently selected instance.
    always_comb begin
        case (sel)
            2'd0:    s_cur = {32'd0, s0};
            2'd1:    s_cur = {32'd0, s1};
            default: s_cur = s2;
        endcase
        rdy_cur = in_ready_v[sel];
        vld_cur = out_valid_v[sel];
        f_cur   = {n_v[sel], z_v[sel], c_v[sel], v_v[sel]};
    end

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] es;
        logic [3:0]  ef;   // {n,z,c,v}
    } vec_t;

    typedef struct {
        logic [63:0] s;
        logic [3:0]  f;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int width_of(input logic [1:0] sl);
        return (sl == 2'd2) ? 64 : 32;
    endfunction

    function automatic int lat_of(input logic [1:0] sl);
        return (sl == 2'd1) ? 1 : 4;
    endfunction

    // Full-width reference: {n,z,c,v,s}
    function automatic logic [67:0] model(input int w, input logic [2:0] o,
                                          input logic [63:0] av, input logic [63:0] bv,
                                          input logic ci);
        logic [63:0] mask, x, y, r;
        logic        k, co, nf, zf, vf;
        logic [64:0] full;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        case (o)
            3'b001:  begin x = av; y = bv;  k = ci;   end
            3'b010:  begin x = av; y = ~bv; k = 1'b1; end
            3'b011:  begin x = av; y = ~bv; k = ci;   end
            3'b100:  begin x = bv; y = ~av; k = 1'b1; end
            3'b101:  begin x = bv; y = ~av; k = ci;   end
            default: begin x = av; y = bv;  k = 1'b0; end
        endcase
        x    = x & mask;
        y    = y & mask;
        full = {1'b0, x} + {1'b0, y} + {64'd0, k};
        r    = full[63:0] & mask;
        co   = full[w];
        nf   = r[w-1];
        zf   = (r == 64'd0);
        vf   = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
        return {nf, zf, co, vf, r};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic add_vec(input logic [1:0] sl, input logic [2:0] o, input logic [63:0] av,
                           input logic [63:0] bv, input logic ci, input logic [63:0] es,
                           input logic [3:0] ef);
        vec_t t;
        t.sel = sl; t.op = o; t.a = av; t.b = bv; t.cin = ci; t.es = es; t.ef = ef;
        vecs.push_back(t);
    endtask

    // Present one operation, push its expectation, and measure latency to out_valid.
    task automatic issue(input vec_t t, input int idx);
        int   guard;
        int   lat;
        exp_t e;
        @(negedge clk);
        sel = t.sel;
        #1;
        guard = 0;
        while (!rdy_cur && guard < 100) begin
            @(negedge clk); #1; guard++;
        end
        if (guard >= 100) chk($sformatf("vec%0d_ready_timeout", idx), 64'(rdy_cur), 64'd1);
        a_bus = t.a; b_bus = t.b; c_in = t.cin; op = t.op; in_valid = 1'b1;
        e.s = t.es; e.f = t.ef;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk($sformatf("vec%0d_accept_ready_low", idx), 64'(rdy_cur), 64'd0);
        lat = 0;
        while (!vld_cur && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        chk($sformatf("vec%0d_latency", idx), 64'(lat), 64'(lat_of(t.sel)));
    endtask

    // Pop the expectation for the result now on the outputs, then take it.
    task automatic collect(input int idx);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk($sformatf("vec%0d_scoreboard_empty", idx), 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_out_valid", idx), 64'(vld_cur), 64'd1);
            chk($sformatf("vec%0d_s", idx), s_cur, e.s);
            chk($sformatf("vec%0d_nzcv", idx), 64'(f_cur), 64'(e.f));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("vec%0d_valid_drop", idx), 64'(vld_cur), 64'd0);
        chk($sformatf("vec%0d_ready_back", idx), 64'(rdy_cur), 64'd1);
    endtask

    initial begin
        vec_t        t;
        logic [1:0]  rs;
        logic [2:0]  ro;
        logic [63:0] ra, rb, mk;
        logic        rc;
        logic [67:0] m;
        logic        stray;

        rst_n = 1'b0; sel = 2'd0; in_valid = 1'b0; out_ready = 1'b1;
        a_bus = 64'd0; b_bus = 64'd0; c_in = 1'b0; op = 3'b000;

        // Hand-computed vectors.
        add_vec(2'd0, 3'b000, 64'hFFFF_FFFF, 64'h1, 1'b0, 64'h0, 4'b0110);          // ADD wrap
        add_vec(2'd0, 3'b010, 64'h8000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF, 4'b0011);  // SUB ovf
        add_vec(2'd0, 3'b011, 64'h5, 64'h3, 1'b0, 64'h1, 4'b0010);                  // SBC
        add_vec(2'd0, 3'b100, 64'h5, 64'h3, 1'b0, 64'hFFFF_FFFE, 4'b1000);          // RSB
        add_vec(2'd0, 3'b101, 64'h3, 64'h5, 1'b1, 64'h2, 4'b0010);                  // RSC
        add_vec(2'd0, 3'b001, 64'h7FFF_FFFF, 64'h0, 1'b1, 64'h8000_0000, 4'b1001);  // ADC ripple
        add_vec(2'd0, 3'b110, 64'h2, 64'h3, 1'b1, 64'h5, 4'b0000);                  // reserved
        add_vec(2'd0, 3'b111, 64'h7FFF_FFFF, 64'h1, 1'b1, 64'h8000_0000, 4'b1001);  // reserved
        add_vec(2'd0, 3'b010, 64'h5, 64'h5, 1'b0, 64'h0, 4'b0110);                  // SUB to zero
        add_vec(2'd1, 3'b000, 64'hFFFF_FFFF, 64'h1, 1'b0, 64'h0, 4'b0110);
        add_vec(2'd1, 3'b010, 64'h8000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF, 4'b0011);
        add_vec(2'd2, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 4'b0110);
        add_vec(2'd2, 3'b010, 64'h8000_0000_0000_0000, 64'h1, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
        add_vec(2'd2, 3'b000, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0,
                64'h0000_0001_0000_0000, 4'b0000);

        // Random vectors against the full-width model.
        for (int i = 0; i < 12; i++) begin
            rs = 2'($urandom_range(0, 2));
            ro = 3'($urandom_range(0, 7));
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'($urandom_range(0, 1));
            mk = (rs == 2'd2) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
            ra = ra & mk;
            rb = rb & mk;
            m  = model(width_of(rs), ro, ra, rb, rc);
            add_vec(rs, ro, ra, rb, rc, m[63:0], m[67:64]);
        end

        // Reset values.
        #12;
        chk("rst_in_ready", 64'(in_ready_v), 64'h7);
        chk("rst_out_valid", 64'(out_valid_v), 64'h0);
        chk("rst_flags", 64'({n_v, z_v, c_v, v_v}), 64'h0);
        chk("rst_s", {s0, s1} | s2, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i], i);
            collect(i);
        end

        // Backpressure: result held while new operands are offered and ignored.
        add_vec(2'd0, 3'b010, 64'h8000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF, 4'b0011);
        t = vecs[vecs.size() - 1];
        @(negedge clk);
        out_ready = 1'b0;
        issue(t, 100);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1);
            a_bus = {$urandom(), $urandom()};
            b_bus = {$urandom(), $urandom()};
            op    = 3'b000;
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", i), 64'(vld_cur), 64'd1);
            chk($sformatf("bp%0d_ready", i), 64'(rdy_cur), 64'd0);
            chk($sformatf("bp%0d_s", i), s_cur, 64'h7FFF_FFFF);
            chk($sformatf("bp%0d_nzcv", i), 64'(f_cur), 64'h3);
        end
        in_valid = 1'b0;
        collect(100);
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (vld_cur || !rdy_cur) stray = 1'b1;
        end
        chk("bp_operands_not_taken", 64'(stray), 64'd0);

        // Reset in the second RUN cycle discards the operation.
        @(negedge clk);
        sel = 2'd0; a_bus = 64'h2; b_bus = 64'h3; op = 3'b000; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mr_accepted", 64'(rdy_cur), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mr_in_ready", 64'(rdy_cur), 64'd1);
        chk("mr_out_valid", 64'(vld_cur), 64'd0);
        chk("mr_s", s_cur, 64'd0);
        chk("mr_flags", 64'(f_cur), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (vld_cur) stray = 1'b1;
        end
        chk("mr_discarded", 64'(stray), 64'd0);
        add_vec(2'd0, 3'b000, 64'h2, 64'h3, 1'b0, 64'h5, 4'b0000);
        issue(vecs[vecs.size() - 1], 200);
        collect(200);

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
